// File: rtl/mux_pkg.sv
// Shared widths and word types for the N:1 registered selector.
// Pure declarations; no logic, no latency, no flow control.
package mux_pkg;
  localparam int MUX_DW   = 2;
  localparam int MUX_N    = 4;
  localparam int MUX_SELW = 2;

  typedef logic [MUX_DW-1:0]       word_t;
  typedef logic [MUX_N*MUX_DW-1:0] din_vec_t;
endpackage

// File: rtl/mux_sel_core.sv
// Combinational N:1 word selector; zero latency, out-of-range index yields 0.
// No backpressure: output follows din/sel continuously.
module mux_sel_core
  import mux_pkg::*;
#(
  parameter int DW   = MUX_DW,
  parameter int N    = MUX_N,
  parameter int SELW = MUX_SELW
) (
  input  logic [N*DW-1:0] din,
  input  logic [SELW-1:0] sel,
  output logic [DW-1:0]   dout
);

  // Compare against every legal index so an unmatched sel falls through to zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) dout = din[i*DW +: DW];
    end
  end

endmodule

// File: rtl/mux_42.sv
// Registered N:1 selector with a zero-latency tap; dout lags sel/din by one cycle.
// No backpressure; en=0 freezes dout, rst_n low clears it asynchronously.
module mux_42
  import mux_pkg::*;
#(
  parameter int DW   = MUX_DW,
  parameter int N    = MUX_N,
  parameter int SELW = MUX_SELW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N*DW-1:0] din,
  input  logic [SELW-1:0] sel,
  output logic [DW-1:0]   dout_comb,
  output logic [DW-1:0]   dout
);

  mux_sel_core #(
    .DW   (DW),
    .N    (N),
    .SELW (SELW)
  ) u_core (
    .din  (din),
    .sel  (sel),
    .dout (dout_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= '0;
    else if (en) dout <= dout_comb;
  end

endmodule

// File: tb/tb_mux_42.sv
// Bench for mux_42: table vectors, corner sequences and random traffic
// checked against an arithmetic reference of the selector and register.
module tb_mux_42;
  import mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  din_vec_t   din;
  logic [1:0] sel;
  word_t      dout_comb, dout;

  // Non-power-of-two instance: three 2-bit words, 2-bit select.
  logic [5:0] din3;
  logic [1:0] sel3;
  logic [1:0] dout_comb3, dout3;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_dout, exp_dout3;

  always #5 clk = ~clk;

  mux_42 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .sel       (sel),
    .dout_comb (dout_comb),
    .dout      (dout)
  );

  mux_42 #(.DW(2), .N(3), .SELW(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din3),
    .sel       (sel3),
    .dout_comb (dout_comb3),
    .dout      (dout3)
  );

  function automatic logic [1:0] ref_sel(input logic [63:0] d, input int s, input int n);
    logic [63:0] t;
    if (s >= n) return 2'd0;
    t = d >> (s * 2);
    return t[1:0];
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge; the model register updates from inputs held stable across it.
  task automatic step();
    logic [1:0] nxt, nxt3;
    nxt  = !rst_n ? 2'd0 : (en ? ref_sel(64'(din), int'(sel), 4) : exp_dout);
    nxt3 = !rst_n ? 2'd0 : (en ? ref_sel(64'(din3), int'(sel3), 3) : exp_dout3);
    @(posedge clk);
    exp_dout  = nxt;
    exp_dout3 = nxt3;
    #1;
  endtask

  typedef struct {
    logic [7:0] din;
    logic [1:0] sel;
    logic       en;
    logic [1:0] exp_comb;
    logic [1:0] exp_dout;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Words listed 0..3: sweep vector 3,2,1,0 = 8'h1B.
    tbl[0]  = '{8'h1B, 2'd0, 1'b1, 2'd3, 2'd3};
    tbl[1]  = '{8'h1B, 2'd1, 1'b1, 2'd2, 2'd2};
    tbl[2]  = '{8'h1B, 2'd2, 1'b1, 2'd1, 2'd1};
    tbl[3]  = '{8'h1B, 2'd3, 1'b1, 2'd0, 2'd0};
    tbl[4]  = '{8'hDB, 2'd3, 1'b1, 2'd3, 2'd3};  // selected word 3 -> 3
    tbl[5]  = '{8'hD9, 2'd3, 1'b1, 2'd3, 2'd3};  // unselected word 0 -> 1
    tbl[6]  = '{8'h1B, 2'd1, 1'b1, 2'd2, 2'd2};
    tbl[7]  = '{8'h1B, 2'd3, 1'b0, 2'd0, 2'd2};  // hold
    tbl[8]  = '{8'h1B, 2'd3, 1'b0, 2'd0, 2'd2};
    tbl[9]  = '{8'h1B, 2'd3, 1'b0, 2'd0, 2'd2};
    tbl[10] = '{8'h1B, 2'd3, 1'b1, 2'd0, 2'd0};  // release hold

    // Reset with arbitrary data, before any clock edge.
    rst_n = 1'b0; en = 1'b1; din = din_vec_t'($urandom); sel = 2'd2;
    din3 = 6'h1B; sel3 = 2'd0;
    exp_dout = 2'd0; exp_dout3 = 2'd0;
    #1;
    check("reset_dout", dout, 2'd0);
    check("reset_dout3", dout3, 2'd0);
    check("reset_comb", dout_comb, ref_sel(64'(din), 2, 4));
    @(negedge clk);
    rst_n = 1'b1; din = 8'h1B; sel = 2'd2;
    step();
    check("first_load", dout, 2'd1);

    for (int i = 0; i < 11; i++) begin
      din = tbl[i].din; sel = tbl[i].sel; en = tbl[i].en;
      #1;
      check($sformatf("tbl%0d_comb", i), dout_comb, tbl[i].exp_comb);
      step();
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("tbl%0d_model", i), dout, exp_dout);
    end

    // Reset mid-operation with dout=3.
    en = 1'b1; din = 8'h1B; sel = 2'd0;
    step();
    check("pre_rst_dout", dout, 2'd3);
    #2;
    rst_n = 1'b0; exp_dout = 2'd0; exp_dout3 = 2'd0;
    #1;
    check("mid_rst_dout", dout, 2'd0);
    check("mid_rst_comb", dout_comb, 2'd3);
    step();
    check("rst_held", dout, 2'd0);
    rst_n = 1'b1;
    step();
    check("rst_reload", dout, 2'd3);

    // N=3: out-of-range index selects zero.
    din3 = 6'h1B; sel3 = 2'd0;
    step();
    check("n3_load", dout3, 2'd3);
    sel3 = 2'd3;
    #1;
    check("n3_comb_oor", dout_comb3, 2'd0);
    step();
    check("n3_dout_oor", dout3, 2'd0);

    // Random traffic against the model, including occasional async resets.
    for (int i = 0; i < 300; i++) begin
      din  = din_vec_t'($urandom);
      sel  = 2'($urandom_range(0, 3));
      din3 = 6'($urandom);
      sel3 = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0; exp_dout = 2'd0; exp_dout3 = 2'd0;
      end else begin
        rst_n = 1'b1;
      end
      #1;
      check("rnd_comb", dout_comb, ref_sel(64'(din), int'(sel), 4));
      check("rnd_comb3", dout_comb3, ref_sel(64'(din3), int'(sel3), 3));
      check("rnd_pre", dout, exp_dout);
      step();
      check("rnd_dout", dout, exp_dout);
      check("rnd_dout3", dout3, exp_dout3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_42.md
Name: mux_42

Overview:
- Registered N-to-1 data selector; default configuration is a 4-input, 2-bit-wide mux.
- Selects one of N input words by binary index `sel` and presents it on `dout`, registered on `clk`.
- Also provides a combinational path, `dout_comb`, for zero-latency consumers.
- Sits in datapath steering logic wherever a small word must be picked from a fixed set of sources.

Parameters:
- DW, 2, width of each data word in bits (>=1)
- N, 4, number of input words (>=2)
- SELW, 2, select width; must satisfy 2**SELW >= N (default = clog2(N))

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  output-register load enable; when 0, `dout` holds
- din  input  N*DW  packed input words; word i occupies din[i*DW +: DW]
- sel  input  SELW  binary index of the word to forward
- dout_comb  output  DW  combinational selected word, zero latency
- dout  output  DW  registered selected word, one-cycle latency

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous, active-low; all sequential state lives in the `clk` domain.
- Combinational select:
  - dout_comb = din[sel*DW +: DW] when sel < N.
  - dout_comb = 0 when sel >= N (only reachable when N is not a power of two).
  - No latches; dout_comb changes whenever any din word or sel changes.
- Output register:
  - On a rising clk with en=1, dout <= dout_comb.
  - With en=0, dout holds its value.
  - Latency is exactly 1 cycle from sel/din to dout.
- Reset:
  - rst_n low immediately (asynchronously) forces dout = 0, independent of clk.
  - dout_comb is unaffected by reset; it stays a function of din/sel.
  - Release of rst_n is synchronized externally; the first load is the first rising clk with rst_n=1 and en=1.
  - Reset asserted mid-operation discards the held value; no residual state remains.
- Data changes:
  - A change on an unselected word has no effect on either output.
  - A change on the selected word appears on dout_comb in the same cycle and on dout after the next enabled edge.
- Simultaneous sel and din change in one cycle: the output reflects the new sel applied to the new din.
- X handling: sel containing X/Z need not be resolved; the verification bench must drive only known values.
- No handshake, no internal state other than the dout register.

Decomposition:
- Shared package `mux_pkg`:
  - localparams MUX_DW=2, MUX_N=4, MUX_SELW=2.
  - A typedef for the DW-bit word.
  - A typedef for the packed N-word input vector.
- One natural sub-module: `mux_sel_core`.
  - Purely combinational N:1 selector with the out-of-range-zero rule.
  - Instantiated once; the top adds the enable and reset register around it.

Test Plan:
- Reset: rst_n=0 with din arbitrary, no clock edge -> dout=0 immediately; release, en=1, one clk -> dout equals the selected word.
- Sweep (din words 0..3 = 3,2,1,0, en=1): sel=0,1,2,3 on successive cycles -> dout_comb=3,2,1,0 in the same cycle; dout=3,2,1,0 one cycle later.
- Selected-word update: sel=3, then change word 3 from 0 to 3 -> dout_comb=3 immediately, dout=3 after the next edge; changing word 0 to 1 leaves both outputs at 3.
- Enable hold: dout=2, en=0, sel changed to 3 for 3 cycles -> dout stays 2; set en=1 -> dout=0 after one edge.
- Reset mid-operation: dout=3, assert rst_n between edges -> dout=0 at once; deassert -> dout reloads the selected word on the next enabled edge.
- Non-power-of-two config: N=3, SELW=2, sel=3 -> dout_comb=0 and dout=0 one cycle later.
